// File: rtl/fifo_send_pkg.sv
// Shared types and defaults for the parallel-to-byte FIFO loader.
package fifo_send_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [11:0] DEFAULT_LEN     = 12'hC;
    localparam logic [15:0] DEFAULT_TIMEOUT = 16'hFFFF;
    localparam logic [15:0] STALL_MAX       = 16'hFFFF;

endpackage

// File: rtl/fifo_send.sv
// Captures a LEN-byte word on fs and writes it LSB-first into a byte-wide FIFO,
// one byte per cycle, stalling on fifo_full and aborting after TIMEOUT stalls.
module fifo_send
    import fifo_send_pkg::*;
#(
    parameter int unsigned LEN     = DEFAULT_LEN,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN*8-1:0] din,
    input  logic             fs,
    output logic             fd,
    output logic             err,
    input  logic             fifo_full,
    output logic             fifo_txen,
    output logic [7:0]       dout,
    output state_t           dbg_state_o
);

    localparam logic [11:0] LEN_C     = 12'(LEN);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    // Handshake: fs is a level request held until fd or err is seen; fd/err
    // stay high until fs drops, and fs is ignored while a transfer is running.

    state_t             state_q, state_d;
    logic [LEN*8-1:0]   sr_q, sr_d;
    logic [11:0]        cnt_q, cnt_d;
    logic [15:0]        stall_q, stall_d;
    logic               txen_q, txen_d;
    logic [7:0]         dout_q, dout_d;
    logic               fd_q, fd_d;
    logic               err_q, err_d;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        txen_d  = 1'b0;
        dout_d  = dout_q;

        case (state_q)
            ST_IDLE: begin
                if (fs) begin
                    sr_d    = din;
                    cnt_d   = 12'd0;
                    stall_d = 16'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cnt_q == LEN_C) begin
                    state_d = ST_DONE;
                end else if (!fifo_full) begin
                    // Low byte goes out, the register shifts down for the next one.
                    txen_d  = 1'b1;
                    dout_d  = sr_q[7:0];
                    sr_d    = sr_q >> 8;
                    cnt_d   = cnt_q + 12'd1;
                    stall_d = 16'd0;
                end else begin
                    stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + 16'd1;
                    if (stall_d >= TIMEOUT_C) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DONE: begin
                if (!fs) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (!fs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fd_d  = (state_d == ST_DONE);
        err_d = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= 12'd0;
            stall_q <= 16'd0;
            txen_q  <= 1'b0;
            dout_q  <= 8'h00;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            txen_q  <= txen_d;
            dout_q  <= dout_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
        end
    end

    assign fifo_txen   = txen_q;
    assign dout        = dout_q;
    assign fd          = fd_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fifo_send.sv
// Directed bench for fifo_send: reset, streaming, stalls, timeout, mid-transfer reset,
// back-to-back restart, LEN=1 and a byte-level loopback scoreboard.
module tb_fifo_send;
    import fifo_send_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] din;
    logic        fs;
    logic        fd;
    logic        err;
    logic        fifo_full;
    logic        fifo_txen;
    logic [7:0]  dout;
    state_t      dbg_state;

    logic [7:0]  din1;
    logic        fs1;
    logic        fd1;
    logic        err1;
    logic        full1;
    logic        txen1;
    logic [7:0]  dout1;
    state_t      dbg_state1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    localparam logic [95:0] PAT_INC = 96'h0B0A09080706050403020100;

    always #5 clk = ~clk;

    fifo_send #(.LEN(12), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst), .din(din), .fs(fs), .fd(fd), .err(err),
        .fifo_full(fifo_full), .fifo_txen(fifo_txen), .dout(dout),
        .dbg_state_o(dbg_state)
    );

    fifo_send #(.LEN(1), .TIMEOUT(8)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .fs(fs1), .fd(fd1), .err(err1),
        .fifo_full(full1), .fifo_txen(txen1), .dout(dout1),
        .dbg_state_o(dbg_state1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; fs = 1'b1; din = PAT_INC; fifo_full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (fifo_txen !== 1'b0 || fd !== 1'b0 || err !== 1'b0 || dout !== 8'h00 || dbg_state !== ST_IDLE) begin
                errors++;
                $display("FAIL reset_c%0d: txen=%b fd=%b err=%b dout=%h st=%0d exp all 0, IDLE",
                         c, fifo_txen, fd, err, dout, dbg_state);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dbg_state !== ST_SEND || fifo_txen !== 1'b0) begin
            errors++;
            $display("FAIL reset_start: st=%0d txen=%b exp st=1 txen=0", dbg_state, fifo_txen);
        end
        tick();
        checks++;
        if (fifo_txen !== 1'b1 || dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_first_byte: txen=%b dout=%h exp 1/00", fifo_txen, dout);
        end
        drain(12);
        fs = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        din = PAT_INC; fs = 1'b1; fifo_full = 1'b0;
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (fifo_txen !== 1'b1 || dout !== 8'(i) || fd !== 1'b0) begin
                errors++;
                $display("FAIL basic_byte%0d: txen=%b dout=%h fd=%b exp 1/%h/0", i, fifo_txen, dout, fd, 8'(i));
            end
        end
        tick();
        checks++;
        if (fifo_txen !== 1'b0 || fd !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: txen=%b fd=%b exp 0/1", fifo_txen, fd);
        end
        tick();
        checks++;
        if (fd !== 1'b1 || dbg_state !== ST_DONE) begin
            errors++;
            $display("FAIL basic_hold: fd=%b st=%0d exp 1/DONE", fd, dbg_state);
        end
        fs = 1'b0;
        tick();
        checks++;
        if (fd !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL basic_release: fd=%b st=%0d exp 0/IDLE", fd, dbg_state);
        end
    endtask

    task automatic test_stall();
        din = PAT_INC; fs = 1'b1; fifo_full = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (fifo_txen !== 1'b1 || dout !== 8'(i)) begin
                errors++;
                $display("FAIL stall_pre%0d: txen=%b dout=%h exp 1/%h", i, fifo_txen, dout, 8'(i));
            end
        end
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if (fifo_txen !== 1'b0 || dout !== 8'h04 || err !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: txen=%b dout=%h err=%b exp 0/04/0", s, fifo_txen, dout, err);
            end
        end
        fifo_full = 1'b0;
        for (int i = 5; i < 12; i++) begin
            tick();
            checks++;
            if (fifo_txen !== 1'b1 || dout !== 8'(i) || fd !== 1'b0) begin
                errors++;
                $display("FAIL stall_post%0d: txen=%b dout=%h fd=%b exp 1/%h/0", i, fifo_txen, dout, fd, 8'(i));
            end
        end
        tick();
        checks++;
        if (fifo_txen !== 1'b0 || fd !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: txen=%b fd=%b exp 0/1", fifo_txen, fd);
        end
        fs = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        din = PAT_INC; fs = 1'b1; fifo_full = 1'b1;
        tick();
        for (int s = 1; s <= 8; s++) begin
            tick();
            checks++;
            if (fifo_txen !== 1'b0 || fd !== 1'b0 || err !== (s == 8)) begin
                errors++;
                $display("FAIL timeout_c%0d: txen=%b fd=%b err=%b exp 0/0/%0d", s, fifo_txen, fd, err, (s == 8));
            end
        end
        tick();
        checks++;
        if (err !== 1'b1 || dbg_state !== ST_ERR) begin
            errors++;
            $display("FAIL timeout_hold: err=%b st=%0d exp 1/ERR", err, dbg_state);
        end
        fs = 1'b0;
        tick();
        checks++;
        if (err !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL timeout_release: err=%b st=%0d exp 0/IDLE", err, dbg_state);
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_reset_mid();
        din = PAT_INC; fs = 1'b1; fifo_full = 1'b0;
        tick();
        drain(6);
        rst = 1'b1; fs = 1'b0;
        tick();
        checks++;
        if (fifo_txen !== 1'b0 || fd !== 1'b0 || err !== 1'b0 || dout !== 8'h00 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL rstmid_outputs: txen=%b fd=%b err=%b dout=%h st=%0d exp all 0, IDLE",
                     fifo_txen, fd, err, dout, dbg_state);
        end
        rst = 1'b0;
        din = {96{1'b1}}; fs = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (fifo_txen !== 1'b1 || dout !== 8'hFF) begin
                errors++;
                $display("FAIL rstmid_byte%0d: txen=%b dout=%h exp 1/ff", i, fifo_txen, dout);
            end
        end
        tick();
        checks++;
        if (fd !== 1'b1 || fifo_txen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_done: fd=%b txen=%b exp 1/0", fd, fifo_txen);
        end
        fs = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        din = PAT_INC; fs = 1'b1; fifo_full = 1'b0;
        tick();
        drain(13);
        fs = 1'b0;
        tick();
        checks++;
        if (dbg_state !== ST_IDLE || fd !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: st=%0d fd=%b exp IDLE/0", dbg_state, fd);
        end
        fs = 1'b1; din = 96'hC0FFEE00_12345678_9ABCDE5A;
        tick();
        checks++;
        if (dbg_state !== ST_SEND) begin
            errors++;
            $display("FAIL b2b_restart: st=%0d exp SEND", dbg_state);
        end
        din = '0;
        tick();
        checks++;
        if (fifo_txen !== 1'b1 || dout !== 8'h5A) begin
            errors++;
            $display("FAIL b2b_byte0: txen=%b dout=%h exp 1/5a", fifo_txen, dout);
        end
        tick();
        checks++;
        if (fifo_txen !== 1'b1 || dout !== 8'hDE) begin
            errors++;
            $display("FAIL b2b_byte1: txen=%b dout=%h exp 1/de", fifo_txen, dout);
        end
        drain(11);
        fs = 1'b0;
        tick();
    endtask

    task automatic test_len1();
        din1 = 8'hA5; fs1 = 1'b1;
        tick();
        tick();
        checks++;
        if (txen1 !== 1'b1 || dout1 !== 8'hA5 || fd1 !== 1'b0) begin
            errors++;
            $display("FAIL len1_write: txen=%b dout=%h fd=%b exp 1/a5/0", txen1, dout1, fd1);
        end
        tick();
        checks++;
        if (txen1 !== 1'b0 || fd1 !== 1'b1) begin
            errors++;
            $display("FAIL len1_done: txen=%b fd=%b exp 0/1", txen1, fd1);
        end
        fs1 = 1'b0;
        tick();
    endtask

    task automatic test_loopback();
        logic done;
        int   consec;
        for (int w = 0; w < 100; w++) begin
            din = {$urandom, $urandom, $urandom};
            exp_q.delete();
            for (int k = 0; k < 12; k++) exp_q.push_back(din[8*k +: 8]);
            fs = 1'b1; consec = 0; done = 1'b0;
            for (int c = 0; c < 100 && !done; c++) begin
                fifo_full = (consec >= 3) ? 1'b0 : ($urandom_range(0, 3) == 0);
                consec = fifo_full ? consec + 1 : 0;
                tick();
                if (fifo_txen) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL loop_w%0d_extra: got=%h exp no write", w, dout);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (dout !== e) begin
                            errors++;
                            $display("FAIL loop_w%0d_byte: got=%h exp=%h", w, dout, e);
                        end
                    end
                end
                if (fd || err) done = 1'b1;
            end
            checks++;
            if (!done || err !== 1'b0 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL loop_w%0d_end: done=%b err=%b left=%0d exp 1/0/0", w, done, err, exp_q.size());
            end
            fs = 1'b0; fifo_full = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; fs = 1'b0; din = '0; fifo_full = 1'b0;
        din1 = 8'h00; fs1 = 1'b0; full1 = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_len1();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
